// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-port ROM read arbiter: size defaults for the
// 1 KB ROM, the default read latency and the port-id encoding.
package rom_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_ADDR_WIDTH   = 10;
    localparam int DEFAULT_READ_LATENCY = 2;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // One slot of the in-flight tracker: is a read outstanding, and for whom.
    typedef struct packed {
        logic  valid;
        port_e port;
    } inflight_t;

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-way grant logic: round-robin on the last accepted port, or fixed
// priority to port 0. A lone requester is always granted in the same cycle.
module rr_arb2
    import rom_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_e lastPort_q;
    port_e lastPort_d;

    // Pointer starts at "port 1 last" so port 0 wins the first conflict; it
    // only moves when a grant is issued, which is always an accepted read.
    always_comb begin
        gnt_o      = 2'b00;
        lastPort_d = lastPort_q;
        if (!rst) begin
            if (req_i == 2'b11) begin
                gnt_o = ((FIXED_PRIO != 0) || (lastPort_q == PORT1)) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
        if (gnt_o != 2'b00) begin
            lastPort_d = gnt_o[1] ? PORT1 : PORT0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastPort_q <= PORT1;
        end else begin
            lastPort_q <= lastPort_d;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one ROM read port between two requesters; tracks outstanding reads
// and steers each returning word back to the port that issued it.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int FIXED_PRIO   = 0
) (
`ifdef USE_POWER_PINS
    inout  wire                   vccd1,
    inout  wire                   vssd1,
`endif
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rom_cs,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout
);

    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] lastAddr_q;
    logic [ADDR_WIDTH-1:0] lastAddr_d;
    inflight_t             inflight_q [READ_LATENCY];
    inflight_t             newEntry;
    inflight_t             tail;
    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) uArb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({req1, req0}),
        .gnt_o (gnt)
    );

    assign gnt0   = gnt[0];
    assign gnt1   = gnt[1];
    assign rom_cs = gnt[0] | gnt[1];
    assign tail   = inflight_q[READ_LATENCY-1];

    // The ROM sees the granted address; when idle it keeps the last issued one
    // so the address bus does not toggle needlessly.
    always_comb begin
        rom_addr   = lastAddr_q;
        lastAddr_d = lastAddr_q;
        newEntry   = '{valid: rom_cs, port: (gnt[1] ? PORT1 : PORT0)};
        if (rst) begin
            rom_addr = '0;
        end else if (gnt[0]) begin
            rom_addr = addr0;
        end else if (gnt[1]) begin
            rom_addr = addr1;
        end
        if (rom_cs) begin
            lastAddr_d = rom_addr;
        end
    end

    // The tracker is exactly READ_LATENCY deep, so its tail lines up with the
    // cycle in which rom_dout carries that read's data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                inflight_q[i] <= '0;
            end
            lastAddr_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            inflight_q[0] <= newEntry;
            for (int i = 1; i < READ_LATENCY; i++) begin
                inflight_q[i] <= inflight_q[i-1];
            end
            lastAddr_q <= lastAddr_d;
            rvalid0_q  <= tail.valid && (tail.port == PORT0);
            rvalid1_q  <= tail.valid && (tail.port == PORT1);
            if (tail.valid && (tail.port == PORT0)) begin
                rdata0_q <= rom_dout;
            end
            if (tail.valid && (tail.port == PORT1)) begin
                rdata1_q <= rom_dout;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed and randomised checks of rom_arbiter in round-robin and fixed
// priority builds, each driving its own behavioural 2-cycle ROM.
module tb_rom_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [9:0] addr0, addr1;
    logic       gnt0, gnt1, rvalid0, rvalid1, romCs;
    logic [7:0] rdata0, rdata1, romDout;
    logic [9:0] romAddr;
    logic [9:0] romA1;

    logic       fpReq0, fpReq1;
    logic [9:0] fpAddr0, fpAddr1;
    logic       fpGnt0, fpGnt1, fpRvalid0, fpRvalid1, fpRomCs;
    logic [7:0] fpRdata0, fpRdata1, fpRomDout;
    logic [9:0] fpRomAddr;
    logic [9:0] fpRomA1;

    int compared;
    int mismatched;

    rom_arbiter #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (10),
        .READ_LATENCY (2),
        .FIXED_PRIO   (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .addr0    (addr0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .rdata0   (rdata0),
        .req1     (req1),
        .addr1    (addr1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata1   (rdata1),
        .rom_cs   (romCs),
        .rom_addr (romAddr),
        .rom_dout (romDout)
    );

    rom_arbiter #(
        .DATA_WIDTH   (8),
        .ADDR_WIDTH   (10),
        .READ_LATENCY (2),
        .FIXED_PRIO   (1)
    ) dutFp (
        .clk      (clk),
        .rst      (rst),
        .req0     (fpReq0),
        .addr0    (fpAddr0),
        .gnt0     (fpGnt0),
        .rvalid0  (fpRvalid0),
        .rdata0   (fpRdata0),
        .req1     (fpReq1),
        .addr1    (fpAddr1),
        .gnt1     (fpGnt1),
        .rvalid1  (fpRvalid1),
        .rdata1   (fpRdata1),
        .rom_cs   (fpRomCs),
        .rom_addr (fpRomAddr),
        .rom_dout (fpRomDout)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: input register then output register, data = addr ^ A5.
    always @(posedge clk) begin
        romA1     <= romAddr;
        romDout   <= romA1[7:0] ^ 8'hA5;
        fpRomA1   <= fpRomAddr;
        fpRomDout <= fpRomA1[7:0] ^ 8'hA5;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'h155; addr1 = 10'h2AA;
        fpReq0 = 1'b1; fpReq1 = 1'b1; fpAddr0 = 10'h155; fpAddr1 = 10'h2AA;
        tick();
        tick();
        #1;
        compared++;
        if ({gnt0, gnt1, romCs} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_grants: got gnt0/gnt1/cs=%b expected 000", {gnt0, gnt1, romCs});
        end
        compared++;
        if (romAddr !== 10'h000) begin
            mismatched++;
            $display("[TB] FAIL reset_rom_addr: got %h expected 000", romAddr);
        end
        compared++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !== 18'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_returns: got rv=%b%b d0=%h d1=%h expected all zero",
                     rvalid0, rvalid1, rdata0, rdata1);
        end
        compared++;
        if ({fpGnt0, fpGnt1, fpRomCs} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_fp_grants: got %b expected 000", {fpGnt0, fpGnt1, fpRomCs});
        end
        req0 = 1'b0; req1 = 1'b0; fpReq0 = 1'b0; fpReq1 = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic       expRv0, expRv1;
        logic [9:0] expAddr;
        addr0 = 10'h010; addr1 = 10'h020;
        for (int c = 0; c < 10; c++) begin
            expRv0 = (c >= 3) && (c < 9) && (((c - 3) % 2) == 0);
            expRv1 = (c >= 3) && (c < 9) && (((c - 3) % 2) == 1);
            compared++;
            if ({rvalid0, rvalid1} !== {expRv0, expRv1}) begin
                mismatched++;
                $display("[TB] FAIL rr_rvalid c=%0d: got %b%b expected %b%b", c, rvalid0, rvalid1, expRv0, expRv1);
            end
            if (expRv0) begin
                compared++;
                if (rdata0 !== 8'hB5) begin
                    mismatched++;
                    $display("[TB] FAIL rr_rdata0 c=%0d: got %h expected b5", c, rdata0);
                end
            end
            if (expRv1) begin
                compared++;
                if (rdata1 !== 8'h85) begin
                    mismatched++;
                    $display("[TB] FAIL rr_rdata1 c=%0d: got %h expected 85", c, rdata1);
                end
            end
            req0 = (c < 6); req1 = (c < 6);
            #1;
            if (c < 6) begin
                expAddr = ((c % 2) == 0) ? 10'h010 : 10'h020;
                compared++;
                if ({gnt0, gnt1, romCs, romAddr} !== {((c % 2) == 0), ((c % 2) == 1), 1'b1, expAddr}) begin
                    mismatched++;
                    $display("[TB] FAIL rr_grant c=%0d: got g=%b%b cs=%b a=%h expected g=%b%b cs=1 a=%h",
                             c, gnt0, gnt1, romCs, romAddr, ((c % 2) == 0), ((c % 2) == 1), expAddr);
                end
            end
            tick();
        end
    endtask

    task automatic test_single();
        req0 = 1'b1; addr0 = 10'h003;
        #1;
        compared++;
        if ({gnt0, gnt1, romCs, romAddr} !== {3'b101, 10'h003}) begin
            mismatched++;
            $display("[TB] FAIL single_grant: got g=%b%b cs=%b a=%h expected g=10 cs=1 a=003",
                     gnt0, gnt1, romCs, romAddr);
        end
        tick();
        req0 = 1'b0;
        #1;
        compared++;
        if ({romCs, romAddr} !== {1'b0, 10'h003}) begin
            mismatched++;
            $display("[TB] FAIL single_idle_addr: got cs=%b a=%h expected cs=0 a=003", romCs, romAddr);
        end
        for (int c = 1; c <= 5; c++) begin
            compared++;
            if ({rvalid0, rvalid1} !== {(c == 3), 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL single_rvalid c=%0d: got %b%b expected %b0", c, rvalid0, rvalid1, (c == 3));
            end
            if (c >= 3) begin
                compared++;
                if (rdata0 !== 8'hA6) begin
                    mismatched++;
                    $display("[TB] FAIL single_rdata0 c=%0d: got %h expected a6", c, rdata0);
                end
            end
            tick();
        end
    endtask

    task automatic test_fixed_prio();
        fpAddr0 = 10'h010; fpAddr1 = 10'h020;
        for (int c = 0; c < 8; c++) begin
            compared++;
            if ({fpRvalid0, fpRvalid1} !== {((c >= 3) && (c < 7)), 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL fp_rvalid c=%0d: got %b%b expected %b0", c, fpRvalid0, fpRvalid1,
                         ((c >= 3) && (c < 7)));
            end
            if ((c >= 3) && (c < 7)) begin
                compared++;
                if (fpRdata0 !== 8'hB5) begin
                    mismatched++;
                    $display("[TB] FAIL fp_rdata0 c=%0d: got %h expected b5", c, fpRdata0);
                end
            end
            fpReq0 = (c < 4); fpReq1 = (c < 4);
            #1;
            if (c < 4) begin
                compared++;
                if ({fpGnt0, fpGnt1} !== 2'b10) begin
                    mismatched++;
                    $display("[TB] FAIL fp_grant c=%0d: got %b%b expected 10", c, fpGnt0, fpGnt1);
                end
            end
            tick();
        end
        fpReq0 = 1'b0; fpReq1 = 1'b0;
    endtask

    task automatic test_reset_inflight();
        req0 = 1'b1; addr0 = 10'h040; req1 = 1'b0;
        #1;
        compared++;
        if ({gnt0, gnt1} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL rstfl_grant0: got %b%b expected 10", gnt0, gnt1);
        end
        tick();
        req0 = 1'b0; req1 = 1'b1; addr1 = 10'h050;
        #1;
        compared++;
        if ({gnt0, gnt1} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL rstfl_grant1: got %b%b expected 01", gnt0, gnt1);
        end
        tick();
        req1 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if ({rdata0, rdata1} !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL rstfl_rdata_cleared: got d0=%h d1=%h expected 00 00", rdata0, rdata1);
        end
        for (int c = 3; c <= 8; c++) begin
            compared++;
            if ({rvalid0, rvalid1} !== {(c == 6), 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL rstfl_rvalid c=%0d: got %b%b expected %b0", c, rvalid0, rvalid1, (c == 6));
            end
            if (c == 6) begin
                compared++;
                if (rdata0 !== 8'h5A) begin
                    mismatched++;
                    $display("[TB] FAIL rstfl_rdata0: got %h expected 5a", rdata0);
                end
            end
            req0 = (c == 3); addr0 = 10'h0FF;
            #1;
            if (c == 3) begin
                compared++;
                if ({gnt0, romAddr} !== {1'b1, 10'h0FF}) begin
                    mismatched++;
                    $display("[TB] FAIL rstfl_first_grant: got g0=%b a=%h expected g0=1 a=0ff", gnt0, romAddr);
                end
            end
            tick();
        end
        req0 = 1'b0;
    endtask

    task automatic test_stress();
        int         expPort[$];
        logic [7:0] expData[$];
        int         expDue[$];
        int         lastAcc;
        logic       prevGnt0, prevGnt1;
        logic       expWin1;
        int         gotPort;
        logic [7:0] gotData;
        lastAcc  = 0;
        prevGnt0 = 1'b1;
        prevGnt1 = 1'b1;
        for (int cyc = 0; cyc < 10010; cyc++) begin
            if (rvalid0 || rvalid1) begin
                compared++;
                gotPort = rvalid1 ? 1 : 0;
                gotData = rvalid1 ? rdata1 : rdata0;
                if (rvalid0 && rvalid1) begin
                    mismatched++;
                    $display("[TB] FAIL stress_both_rvalid cyc=%0d: got 11 expected at most one", cyc);
                end else if (expPort.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL stress_spurious cyc=%0d: got rvalid on port %0d expected none", cyc, gotPort);
                end else begin
                    if ((gotPort !== expPort[0]) || (gotData !== expData[0]) || (expDue[0] != cyc)) begin
                        mismatched++;
                        $display("[TB] FAIL stress_return cyc=%0d: got port %0d data %h expected port %0d data %h due %0d",
                                 cyc, gotPort, gotData, expPort[0], expData[0], expDue[0]);
                    end
                    void'(expPort.pop_front());
                    void'(expData.pop_front());
                    void'(expDue.pop_front());
                end
            end else if ((expDue.size() != 0) && (expDue[0] <= cyc)) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL stress_missing cyc=%0d: got no rvalid expected port %0d data %h",
                         cyc, expPort[0], expData[0]);
                void'(expPort.pop_front());
                void'(expData.pop_front());
                void'(expDue.pop_front());
            end
            if (cyc < 10000) begin
                if (!req0 || prevGnt0) begin
                    req0  = 1'($urandom_range(0, 1));
                    addr0 = 10'($urandom_range(0, 1023));
                end
                if (!req1 || prevGnt1) begin
                    req1  = 1'($urandom_range(0, 1));
                    addr1 = 10'($urandom_range(0, 1023));
                end
            end else begin
                req0 = 1'b0; req1 = 1'b0;
            end
            #1;
            expWin1 = (lastAcc == 0);
            compared++;
            if ((gnt0 && gnt1) || (gnt0 && !req0) || (gnt1 && !req1) || (romCs !== (gnt0 | gnt1))
                || (req0 && !req1 && !gnt0) || (req1 && !req0 && !gnt1)
                || (req0 && req1 && (gnt1 !== expWin1 || gnt0 !== !expWin1))) begin
                mismatched++;
                $display("[TB] FAIL stress_grant cyc=%0d: got req=%b%b gnt=%b%b cs=%b expected winner port %0d",
                         cyc, req0, req1, gnt0, gnt1, romCs, expWin1 ? 1 : 0);
            end
            if (gnt0 || gnt1) begin
                compared++;
                if (romAddr !== (gnt1 ? addr1 : addr0)) begin
                    mismatched++;
                    $display("[TB] FAIL stress_rom_addr cyc=%0d: got %h expected %h", cyc, romAddr,
                             gnt1 ? addr1 : addr0);
                end
                lastAcc = gnt1 ? 1 : 0;
                expPort.push_back(lastAcc);
                expData.push_back((gnt1 ? addr1[7:0] : addr0[7:0]) ^ 8'hA5);
                expDue.push_back(cyc + 3);
            end
            prevGnt0 = gnt0;
            prevGnt1 = gnt1;
            tick();
        end
        compared++;
        if (expPort.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL stress_drain: got %0d reads outstanding expected 0", expPort.size());
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        clk = 1'b0;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        fpReq0 = 1'b0; fpReq1 = 1'b0; fpAddr0 = '0; fpAddr1 = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_fixed_prio();
        test_reset_inflight();
        test_stress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 8, ROM word width.
- ADDR_WIDTH, 10, ROM address width.
- READ_LATENCY, 2, cycles from rom_cs asserted to rom_dout valid, including the wrapper's input register; legal 1..4.
- FIXED_PRIO, 0, 0 = round-robin, 1 = port 0 always wins.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 read request; held until granted.
- addr0  input  ADDR_WIDTH  port 0 address; stable while req0 is high.
- gnt0  output  1  combinational grant; a read is accepted in any cycle with req0 && gnt0.
- rvalid0  output  1  registered one-cycle pulse: rdata0 valid.
- rdata0  output  DATA_WIDTH  registered read data for port 0.
- req1, addr1, gnt1, rvalid1, rdata1: same as the port 0 signals, for port 1.
- rom_cs  output  1  chip select to the ROM wrapper.
- rom_addr  output  ADDR_WIDTH  address to the ROM wrapper.
- rom_dout  input  DATA_WIDTH  data from the ROM wrapper.
REQ-003 Under USE_POWER_PINS, the block SHALL carry inout vccd1/vssd1 pins, listed before clk.

Function
REQ-004 At most one grant SHALL be asserted per cycle; gntN SHALL be 0 whenever reqN is 0.
REQ-005 Arbitration SHALL accept one read per cycle, with no bubble between back-to-back grants.
REQ-006 When FIXED_PRIO=0 and both ports request, the port not granted most recently SHALL win; the last-grant pointer updates only on an accepted read.
REQ-007 When FIXED_PRIO=1, port 0 SHALL win every conflict.
REQ-008 A lone requester SHALL be granted in the same cycle it requests.
REQ-009 rom_cs SHALL equal (gnt0|gnt1) combinationally; rom_addr SHALL be the granted port's address, or the last issued address when idle.
REQ-010 In-flight tracking: a READ_LATENCY-deep shift register of {valid, port_id} SHALL shift every cycle and record each accepted read.
REQ-011 Return path: when the tail entry is valid, rom_dout SHALL be captured into rdata[port_id], and rvalid[port_id] SHALL pulse.
REQ-012 Latency: a read accepted in cycle k SHALL produce rvalid in cycle k+READ_LATENCY+1.
REQ-013 Returns SHALL arrive in issue order, with no backpressure; requesters SHALL always accept rvalid.
REQ-014 rdataN SHALL hold its last value until the next return to port N.
REQ-015 Both rvalid signals SHALL never be high in the same cycle.
REQ-016 Requests SHALL need no re-arm: a port holding req high SHALL be granted again on alternate cycles under contention, or every cycle when alone.

Reset
REQ-017 While rst is high, the block SHALL force: gnt0/1=0, rom_cs=0, rom_addr=0, rvalid0/1=0, rdata0/1=0, all in-flight entries invalid, round-robin pointer = "port 1 last", so port 0 wins the first conflict.
REQ-018 A reset asserted with reads in flight SHALL drop those reads; no rvalid SHALL appear for them after reset deasserts.
REQ-019 Reads SHALL be accepted from the first cycle after rst deasserts.

Structure
REQ-020 A shared package/include SHALL hold the DATA_WIDTH/ADDR_WIDTH defaults (8/10, matching the 1 KB ROM), the READ_LATENCY default and the port-id encoding (PORT0=0, PORT1=1).
REQ-021 A sub-module rr_arb2 SHALL hold the 2-way round-robin/fixed-priority grant logic and pointer; the pipeline tracker and return registers SHALL stay in rom_arbiter.
REQ-022 rom_arbiter SHALL instantiate the ROM wrapper only in the integration level, not internally.

Verification
REQ-023 The bench SHALL use a behavioural ROM model, data = addr[7:0] ^ 8'hA5, with READ_LATENCY=2, and cover:
- req0 alone, addr0=10'h003, one cycle -> gnt0 in the same cycle; rvalid0 3 cycles later with rdata0=8'hA6; rvalid1 never high.
- req0 and req1 both held 6 cycles, addr0=10'h010, addr1=10'h020 -> grants alternate 0,1,0,1,0,1; returns alternate 8'hB5/8'h85 in back-to-back cycles.
- FIXED_PRIO=1, both held 4 cycles -> gnt0 every cycle, gnt1 never; 4 port-0 returns.
- Reset asserted one cycle after two accepted reads -> no rvalid on either port afterwards; the first request after reset to addr 10'h0FF returns 8'h5A at latency 3.
- Random req/addr stress, 10k cycles, scoreboard -> every accepted read returns exactly once, in order, to the right port, with correct data; gnt one-hot-or-zero every cycle.
